// File: rtl/hyperbus_native_mem.sv
// Hyperbus native-interface responder backed by byte-lane RAM.
// Reads start after a programmable latency; reads and writes stream one word per cycle.
module hyperbus_native_mem #(
  parameter int HBUS_ADDR_WIDTH = 32,
  parameter int HBUS_DATA_WIDTH = 16,
  parameter int MEM_ADDR_WIDTH  = 10,
  parameter int LATENCY         = 6
) (
  input  logic                         hbus_clk,
  input  logic                         hbus_rst,
  input  logic [HBUS_ADDR_WIDTH-1:0]   hbus_adr_i,
  input  logic [HBUS_DATA_WIDTH-1:0]   hbus_dat_i,
  input  logic [HBUS_DATA_WIDTH/8-1:0] hbus_mask_i,
  input  logic                         hbus_rrq,
  input  logic                         hbus_wrq,
  output logic [HBUS_DATA_WIDTH-1:0]   hbus_dat_o,
  output logic                         hbus_ready,
  output logic                         hbus_valid
);
  localparam int NUM_LANES = HBUS_DATA_WIDTH / 8;
  localparam int DEPTH     = 1 << MEM_ADDR_WIDTH;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LAT,
    ST_READ,
    ST_WRITE,
    ST_RECOVER
  } state_t;

  state_t                    state_reg, state_next;
  logic [MEM_ADDR_WIDTH-1:0] idx_reg, idx_next;
  logic [7:0]                cnt_reg, cnt_next;
  logic                      ready_reg, ready_next;
  logic                      valid_reg, valid_next;
  logic                      wr_en;
  logic [MEM_ADDR_WIDTH-1:0] wr_idx;
  logic                      rd_en;

  // Only the low address bits index the RAM; the rest alias.
  logic unused_adr_hi;
  assign unused_adr_hi = ^hbus_adr_i[HBUS_ADDR_WIDTH-1:MEM_ADDR_WIDTH];

  always_comb begin
    state_next = state_reg;
    idx_next   = idx_reg;
    cnt_next   = cnt_reg;
    valid_next = 1'b0;
    wr_en      = 1'b0;
    wr_idx     = idx_reg;
    rd_en      = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (hbus_rrq) begin
          state_next = ST_LAT;
          idx_next   = hbus_adr_i[MEM_ADDR_WIDTH-1:0];
          cnt_next   = 8'(LATENCY - 1);
        end else if (hbus_wrq) begin
          state_next = ST_WRITE;
          wr_en      = 1'b1;
          wr_idx     = hbus_adr_i[MEM_ADDR_WIDTH-1:0];
          idx_next   = hbus_adr_i[MEM_ADDR_WIDTH-1:0] + 1'b1;
        end
      end
      // The edge on which the latency counter expires already delivers the
      // first beat, so valid rises exactly LATENCY edges after acceptance.
      ST_LAT, ST_READ: begin
        if (state_reg == ST_LAT && cnt_reg != 8'd0) begin
          cnt_next = cnt_reg - 1'b1;
        end else if (hbus_rrq) begin
          state_next = ST_READ;
          rd_en      = 1'b1;
          valid_next = 1'b1;
          idx_next   = idx_reg + 1'b1;
        end else begin
          state_next = ST_RECOVER;
        end
      end
      ST_WRITE: begin
        if (hbus_wrq) begin
          wr_en    = 1'b1;
          idx_next = idx_reg + 1'b1;
        end else begin
          state_next = ST_RECOVER;
        end
      end
      ST_RECOVER: state_next = ST_IDLE;
      default:    state_next = ST_IDLE;
    endcase
    ready_next = (state_next == ST_IDLE) || (state_next == ST_WRITE);
  end

  always_ff @(posedge hbus_clk) begin
    if (hbus_rst) begin
      state_reg <= ST_IDLE;
      idx_reg   <= '0;
      cnt_reg   <= '0;
      ready_reg <= 1'b0;
      valid_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      idx_reg   <= idx_next;
      cnt_reg   <= cnt_next;
      ready_reg <= ready_next;
      valid_reg <= valid_next;
    end
  end

  assign hbus_ready = ready_reg;
  assign hbus_valid = valid_reg;

  // One RAM per byte lane so each mask bit is a plain write enable.
  for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_lane
    logic [7:0] mem [0:DEPTH-1];
    logic [7:0] rd_byte_reg;

    always_ff @(posedge hbus_clk) begin
      if (wr_en && !hbus_rst && !hbus_mask_i[gi]) begin
        mem[wr_idx] <= hbus_dat_i[gi*8 +: 8];
      end
    end

    always_ff @(posedge hbus_clk) begin
      if (hbus_rst) begin
        rd_byte_reg <= '0;
      end else if (rd_en) begin
        rd_byte_reg <= mem[idx_reg];
      end
    end

    assign hbus_dat_o[gi*8 +: 8] = rd_byte_reg;
  end

endmodule

// File: tb/tb_hyperbus_native_mem.sv
// Self-checking bench: randomized bursts against a word-array reference model.
module tb_hyperbus_native_mem;
  localparam int AW    = 32;
  localparam int DW    = 16;
  localparam int MAW   = 10;
  localparam int LAT   = 6;
  localparam int DEPTH = 1 << MAW;

  logic          hbus_clk = 1'b0;
  logic          hbus_rst;
  logic [AW-1:0] hbus_adr_i;
  logic [DW-1:0] hbus_dat_i;
  logic [1:0]    hbus_mask_i;
  logic          hbus_rrq;
  logic          hbus_wrq;
  logic [DW-1:0] hbus_dat_o;
  logic          hbus_ready;
  logic          hbus_valid;

  int errors = 0;
  int checks = 0;

  logic [15:0] ref_mem [DEPTH];
  logic [1:0]  ref_wr  [DEPTH];

  hyperbus_native_mem #(
    .HBUS_ADDR_WIDTH(AW),
    .HBUS_DATA_WIDTH(DW),
    .MEM_ADDR_WIDTH (MAW),
    .LATENCY        (LAT)
  ) dut (
    .hbus_clk   (hbus_clk),
    .hbus_rst   (hbus_rst),
    .hbus_adr_i (hbus_adr_i),
    .hbus_dat_i (hbus_dat_i),
    .hbus_mask_i(hbus_mask_i),
    .hbus_rrq   (hbus_rrq),
    .hbus_wrq   (hbus_wrq),
    .hbus_dat_o (hbus_dat_o),
    .hbus_ready (hbus_ready),
    .hbus_valid (hbus_valid)
  );

  always #5 hbus_clk = ~hbus_clk;

  task automatic tick();
    @(posedge hbus_clk);
    #1;
  endtask

  task automatic model_write(input int idx, input logic [15:0] d, input logic [1:0] m);
    for (int b = 0; b < 2; b++) begin
      if (!m[b]) begin
        ref_mem[idx][b*8 +: 8] = d[b*8 +: 8];
        ref_wr[idx][b] = 1'b1;
      end
    end
  endtask

  task automatic wait_ready(input string name);
    int n = 0;
    while (hbus_ready !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    checks++;
    if (hbus_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s: ready timeout, got ready=%b required 1", name, hbus_ready);
    end
  endtask

  task automatic do_write(input logic [31:0] addr, input logic [15:0] dq[$],
                          input logic [1:0] mq[$], input string name);
    wait_ready(name);
    hbus_adr_i = addr;
    hbus_wrq   = 1'b1;
    for (int i = 0; i < dq.size(); i++) begin
      hbus_dat_i  = dq[i];
      hbus_mask_i = mq[i];
      tick();
      model_write(int'((int'(addr[MAW-1:0]) + i) % DEPTH), dq[i], mq[i]);
      checks++;
      if (hbus_ready !== 1'b1) begin
        errors++;
        $display("FAIL %s: ready during write beat %0d got %b required 1", name, i, hbus_ready);
      end
      hbus_adr_i = $urandom;
    end
    hbus_wrq    = 1'b0;
    hbus_dat_i  = 16'($urandom);
    hbus_mask_i = 2'b00;
    tick();
    checks++;
    if (hbus_ready !== 1'b0 || hbus_valid !== 1'b0) begin
      errors++;
      $display("FAIL %s: recover got ready=%b valid=%b required 0 0", name, hbus_ready, hbus_valid);
    end
    $display("write %s addr=%h beats=%0d", name, addr, dq.size());
  endtask

  // mode 0: plain read; 1: wrq held high too; 2: wrq pulsed during the latency
  task automatic do_read(input logic [31:0] addr, input int n, input int mode, input string name);
    int c = 0;
    int base;
    int idx;
    base = int'(addr[MAW-1:0]);
    wait_ready(name);
    hbus_adr_i  = addr;
    hbus_rrq    = 1'b1;
    hbus_wrq    = (mode == 1);
    hbus_dat_i  = 16'($urandom);
    hbus_mask_i = 2'b00;
    tick();
    hbus_adr_i = $urandom;
    checks++;
    if (hbus_ready !== 1'b0) begin
      errors++;
      $display("FAIL %s: ready after accept got %b required 0", name, hbus_ready);
    end
    while (c < LAT + 10) begin
      if (mode == 2) hbus_wrq = (c == 2);
      tick();
      c++;
      if (hbus_valid === 1'b1) break;
    end
    checks++;
    if (c != LAT || hbus_valid !== 1'b1) begin
      errors++;
      $display("FAIL %s: first valid after %0d edges (valid=%b) required %0d", name, c, hbus_valid, LAT);
      hbus_rrq = 1'b0;
      hbus_wrq = 1'b0;
      tick();
      tick();
      return;
    end
    for (int j = 0; j < n; j++) begin
      if (j > 0) begin
        tick();
        checks++;
        if (hbus_valid !== 1'b1) begin
          errors++;
          $display("FAIL %s: valid beat %0d got %b required 1", name, j, hbus_valid);
        end
      end
      idx = (base + j) % DEPTH;
      if (ref_wr[idx] == 2'b11) begin
        checks++;
        if (hbus_dat_o !== ref_mem[idx]) begin
          errors++;
          $display("FAIL %s: data beat %0d idx=%h got %h required %h", name, j, idx, hbus_dat_o, ref_mem[idx]);
        end
      end
      if (j == n - 1) begin
        hbus_rrq = 1'b0;
        hbus_wrq = 1'b0;
      end
    end
    tick();
    checks++;
    if (hbus_valid !== 1'b0) begin
      errors++;
      $display("FAIL %s: valid after rrq drop got %b required 0", name, hbus_valid);
    end
    $display("read %s addr=%h beats=%0d", name, addr, n);
  endtask

  task automatic test_reset();
    hbus_rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      hbus_rrq    = 1'($urandom);
      hbus_wrq    = 1'($urandom);
      hbus_adr_i  = $urandom;
      hbus_dat_i  = 16'($urandom);
      hbus_mask_i = 2'($urandom);
      tick();
      checks++;
      if (hbus_valid !== 1'b0 || hbus_dat_o !== 16'h0 || hbus_ready !== 1'b0) begin
        errors++;
        $display("FAIL reset_hold: got valid=%b dat=%h ready=%b required 0 0000 0", hbus_valid, hbus_dat_o, hbus_ready);
      end
    end
    hbus_rst = 1'b0;
    hbus_rrq = 1'b0;
    hbus_wrq = 1'b0;
    tick();
    checks++;
    if (hbus_ready !== 1'b1 || hbus_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: got ready=%b valid=%b required 1 0", hbus_ready, hbus_valid);
    end
    $display("reset done");
  endtask

  task automatic test_write_read();
    logic [15:0] dq[$];
    logic [1:0]  mq[$];
    dq = {16'h1234, 16'h5678};
    mq = {2'b00, 2'b00};
    do_write(32'h10, dq, mq, "wr_0x10");
    do_read(32'h10, 2, 0, "rd_0x10");
  endtask

  task automatic test_byte_mask();
    logic [15:0] dq[$];
    logic [1:0]  mq[$];
    logic [15:0] req [4] = '{16'hFFFF, 16'hAB00, 16'h00CD, 16'h1111};
    logic [1:0]  rqm [4] = '{2'b00, 2'b01, 2'b10, 2'b11};
    for (int i = 0; i < 4; i++) begin
      dq = {req[i]};
      mq = {rqm[i]};
      do_write(32'h20, dq, mq, "mask_wr");
      do_read(32'h20, 1, 0, "mask_rd");
    end
  endtask

  task automatic test_wrap();
    logic [15:0] dq[$];
    logic [1:0]  mq[$];
    dq = {16'h0001, 16'h0002, 16'h0003};
    mq = {2'b00, 2'b00, 2'b00};
    do_write(32'h3FE, dq, mq, "wrap_wr");
    do_read(32'h0403FE, 3, 0, "wrap_alias_rd");
    do_read(32'h0, 1, 0, "wrap_zero_rd");
  endtask

  task automatic test_priority();
    logic [15:0] dq[$];
    logic [1:0]  mq[$];
    dq = {16'hBEEF};
    mq = {2'b00};
    do_write(32'h40, dq, mq, "prio_wr");
    do_read(32'h40, 2, 1, "prio_rrq_wrq");
    do_read(32'h40, 1, 0, "prio_check");
    dq = {16'h1357};
    do_write(32'h50, dq, mq, "lat_wr");
    do_read(32'h50, 1, 2, "lat_wrq_pulse");
    do_read(32'h50, 1, 0, "lat_check");
  endtask

  task automatic test_lat_abort();
    int seen = 0;
    wait_ready("abort");
    hbus_adr_i = 32'h10;
    hbus_rrq   = 1'b1;
    tick();
    hbus_rrq = 1'b0;
    for (int i = 0; i < LAT + 3; i++) begin
      tick();
      if (hbus_valid !== 1'b0) seen++;
    end
    checks++;
    if (seen != 0 || hbus_ready !== 1'b1) begin
      errors++;
      $display("FAIL lat_abort: valid beats=%0d ready=%b required 0 1", seen, hbus_ready);
    end
    $display("read abort during latency");
  endtask

  task automatic test_random();
    logic [15:0] dq[$];
    logic [1:0]  mq[$];
    logic [31:0] addr;
    int len;
    for (int it = 0; it < 6; it++) begin
      addr = $urandom;
      len  = int'($urandom_range(1, 4));
      dq.delete();
      mq.delete();
      for (int i = 0; i < len; i++) begin
        dq.push_back(16'($urandom));
        mq.push_back(2'b00);
      end
      do_write(addr, dq, mq, "rnd_full");
      dq.delete();
      mq.delete();
      for (int i = 0; i < len; i++) begin
        dq.push_back(16'($urandom));
        mq.push_back(2'($urandom));
      end
      do_write(addr, dq, mq, "rnd_mask");
      do_read(addr, len, 0, "rnd_rd");
    end
  endtask

  task automatic test_reset_mid_read();
    logic [15:0] dq[$];
    logic [1:0]  mq[$];
    int c = 0;
    for (int i = 0; i < 6; i++) begin
      dq.push_back(16'($urandom));
      mq.push_back(2'b00);
    end
    do_write(32'h100, dq, mq, "mid_wr");
    wait_ready("mid_rd");
    hbus_adr_i = 32'h100;
    hbus_rrq   = 1'b1;
    tick();
    while (hbus_valid !== 1'b1 && c < LAT + 10) begin
      tick();
      c++;
    end
    tick();
    tick();
    checks++;
    if (hbus_valid !== 1'b1 || hbus_dat_o !== ref_mem[16'h102]) begin
      errors++;
      $display("FAIL mid_third_beat: got valid=%b dat=%h required 1 %h", hbus_valid, hbus_dat_o, ref_mem[16'h102]);
    end
    hbus_rst = 1'b1;
    tick();
    checks++;
    if (hbus_valid !== 1'b0 || hbus_dat_o !== 16'h0 || hbus_ready !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset: got valid=%b dat=%h ready=%b required 0 0000 0", hbus_valid, hbus_dat_o, hbus_ready);
    end
    hbus_rst = 1'b0;
    hbus_rrq = 1'b0;
    tick();
    checks++;
    if (hbus_ready !== 1'b1 || hbus_valid !== 1'b0) begin
      errors++;
      $display("FAIL mid_release: got ready=%b valid=%b required 1 0", hbus_ready, hbus_valid);
    end
    $display("reset during read burst");
    do_read(32'h100, 5, 0, "mid_reread");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      ref_mem[i] = 16'h0;
      ref_wr[i]  = 2'b00;
    end
    hbus_rst    = 1'b1;
    hbus_rrq    = 1'b0;
    hbus_wrq    = 1'b0;
    hbus_adr_i  = '0;
    hbus_dat_i  = '0;
    hbus_mask_i = '0;
    test_reset();
    test_write_read();
    test_byte_mask();
    test_wrap();
    test_priority();
    test_lat_abort();
    test_random();
    test_reset_mid_read();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
